// File: rtl/rvvi_pkg.sv
// Shared types and helpers for the RVVI CSR change path.
package rvvi_pkg;

   localparam int unsigned RVVI_CSR36 = 36;
   localparam int unsigned RVVI_CSR54 = 54;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } ser_state_t;

   // Number of set bits; narrower masks are zero-extended by the caller.
   function automatic int unsigned popcount(input logic [RVVI_CSR54-1:0] v);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < RVVI_CSR54; i++) begin
         n += 32'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/csr_lsb_onehot.sv
// Isolates the lowest set bit of a mask and encodes its index.
module csr_lsb_onehot #(
   parameter int unsigned N = 36
) (
   input  logic [N-1:0]         mask,
   output logic [N-1:0]         onehot,
   output logic [$clog2(N)-1:0] idx,
   output logic                 single
);

   localparam int unsigned IW = $clog2(N);

   assign onehot = mask & (~mask + N'(1));
   assign single = (mask != '0) && ((mask & (mask - N'(1))) == '0);

   always_comb begin
      idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (onehot[i]) idx = idx | IW'(i);
      end
   end

endmodule

// File: rtl/csr_change_serializer.sv
// Serializes a multi-hot CSR change set into one-hot beats, lowest index first.
module csr_change_serializer
   import rvvi_pkg::*;
#(
   parameter int unsigned TOTAL_CSRS = RVVI_CSR36,
   parameter int unsigned XLEN       = 64,
   parameter int unsigned CNTW       = $clog2(TOTAL_CSRS + 1)
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       InValid,
   output logic                       InReady,
   input  logic [TOTAL_CSRS-1:0]      InCSRWen,
   input  logic [TOTAL_CSRS*XLEN-1:0] InCSRValues,
   output logic                       OutValid,
   input  logic                       OutReady,
   output logic [TOTAL_CSRS-1:0]      OutCSRWen,
   output logic [XLEN-1:0]            OutCSRValue,
   output logic                       OutFirst,
   output logic                       OutLast,
   output logic [CNTW-1:0]            OutCount,
   output logic                       Busy
);

   localparam int unsigned IW = $clog2(TOTAL_CSRS);

   ser_state_t                 state;
   logic [TOTAL_CSRS-1:0]      pending_mask;
   logic [TOTAL_CSRS*XLEN-1:0] snap;

   logic [TOTAL_CSRS-1:0]      mask_nxt;
   logic [TOTAL_CSRS*XLEN-1:0] snap_nxt;
   logic [TOTAL_CSRS-1:0]      onehot_nxt;
   logic [IW-1:0]              idx_nxt;
   logic [XLEN-1:0]            value_nxt;
   logic                       single_nxt;
   logic                       first_nxt;
   logic                       live_nxt;
   logic                       accept;
   logic                       capture;

   assign accept  = OutValid & OutReady;
   assign InReady = reset_n & ((state == IDLE) | (accept & OutLast));
   assign capture = InValid & InReady & (InCSRWen != '0);

   // Next pending set: a new capture overrides the retiring last beat.
   always_comb begin
      mask_nxt  = pending_mask;
      snap_nxt  = snap;
      first_nxt = OutFirst;
      if (accept) begin
         mask_nxt  = pending_mask & ~OutCSRWen;
         first_nxt = 1'b0;
      end
      if (capture) begin
         mask_nxt  = InCSRWen;
         snap_nxt  = InCSRValues;
         first_nxt = 1'b1;
      end
   end

   assign live_nxt = (mask_nxt != '0);

   csr_lsb_onehot #(
      .N(TOTAL_CSRS)
   ) u_lsb (
      .mask   (mask_nxt),
      .onehot (onehot_nxt),
      .idx    (idx_nxt),
      .single (single_nxt)
   );

   assign value_nxt = snap_nxt[32'(idx_nxt) * XLEN +: XLEN];

   // Outputs are registered from the next pending set so a beat appears the cycle after capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         pending_mask <= '0;
         snap         <= '0;
         OutValid     <= 1'b0;
         OutCSRWen    <= '0;
         OutCSRValue  <= '0;
         OutFirst     <= 1'b0;
         OutLast      <= 1'b0;
         OutCount     <= '0;
         Busy         <= 1'b0;
      end else begin
         state        <= live_nxt ? DRAIN : IDLE;
         pending_mask <= mask_nxt;
         snap         <= snap_nxt;
         OutValid     <= live_nxt;
         OutCSRWen    <= onehot_nxt;
         OutCSRValue  <= live_nxt ? value_nxt : '0;
         OutFirst     <= first_nxt & live_nxt;
         OutLast      <= single_nxt;
         Busy         <= live_nxt;
         if (capture) begin
            OutCount <= CNTW'(popcount(RVVI_CSR54'(InCSRWen)));
         end else if (!live_nxt) begin
            OutCount <= '0;
         end
      end
   end

endmodule

// File: doc/csr_change_serializer.md
Name: csr_change_serializer

Overview:
Sits between the RVVI per-retirement CSR comparator and csrindextoaddr. It takes a multi-hot vector of CSRs changed by one retired instruction, together with a snapshot of all CSR values. It then emits one change per beat as a one-hot CSRWen with its value, lowest index first. The one-hot output drives csrindextoaddr directly, and the per-beat value, count and framing feed the RVVI packetizer.

Parameters:
TOTAL_CSRS, 36, number of tracked CSRs; legal values are 36 and 54, matching the csrindextoaddr index map.
XLEN, 64, CSR value width.
CNTW, $clog2(TOTAL_CSRS+1), width of the change-count fields.

Ports:
clk  in  1  clock.
reset_n  in  1  asynchronous active-low reset.
InValid  in  1  change set offered.
InReady  out  1  block accepts a change set this cycle.
InCSRWen  in  TOTAL_CSRS  multi-hot changed-CSR mask, bit i = CSR index i.
InCSRValues  in  TOTAL_CSRS*XLEN  value snapshot; index i occupies bits [i*XLEN +: XLEN].
OutValid  out  1  beat available.
OutReady  in  1  downstream accepts beat.
OutCSRWen  out  TOTAL_CSRS  one-hot index of the current change.
OutCSRValue  out  XLEN  value of the current CSR.
OutFirst  out  1  first beat of the set.
OutLast  out  1  last beat of the set.
OutCount  out  CNTW  total changes in the current set, constant for every beat of the set.
Busy  out  1  set captured and not fully drained.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; PendingMask=0; value snapshot=0; OutValid=0; OutCSRWen=0; OutCSRValue=0; OutFirst=0; OutLast=0; OutCount=0; Busy=0; InReady=0 while reset_n is low.
- FSM has two states, IDLE and DRAIN.
- InReady = (state==IDLE) | (OutValid & OutReady & OutLast).
- Capture occurs when InValid & InReady:
  - If InCSRWen != 0: register PendingMask=InCSRWen, snapshot values, OutCount=popcount(InCSRWen), FirstFlag=1; go to DRAIN.
  - If InCSRWen == 0: the set is consumed with no beats; stay in or return to IDLE; OutValid stays 0.
- Latency: first beat is valid the cycle after capture. Throughput is 1 beat/cycle with OutReady held high. Back-to-back sets have no bubble: the next capture happens in the same cycle the last beat is accepted.
- In DRAIN:
  - OutValid=1; OutCSRWen = PendingMask & (~PendingMask + 1), the lowest set bit.
  - OutCSRValue = snapshot slice at that index.
  - OutFirst = FirstFlag; OutLast = (PendingMask has exactly one bit set); Busy=1.
- Beat accept (OutValid & OutReady): clear that bit in PendingMask; FirstFlag=0. If OutLast, go to IDLE unless a new capture occurs in the same cycle, in which case stay in DRAIN with the new set.
- Stall (OutValid & ~OutReady): all Out* payload held stable; OutValid never drops without a handshake.
- In IDLE: OutValid=0; OutCSRWen=0, which csrindextoaddr maps to address 0x000; OutFirst=OutLast=0.
- Single-change set: OutFirst=OutLast=1 on the same beat.
- InCSRWen/InCSRValues changes while InReady=0 are ignored; upstream holds them under the valid/ready rule.
- reset_n asserted mid-drain: remaining beats are discarded, no partial output.

Decomposition:
- Package rvvi_pkg holds RVVI_CSR36=36, RVVI_CSR54=54, and enum typedef ser_state_t {IDLE, DRAIN}.
- One sub-module: csr_lsb_onehot (combinational lowest-set-bit isolate plus one-hot-to-index encoder, parameter N). It is used for OutCSRWen and the value mux select.
- Popcount is a function in rvvi_pkg.

Test Plan:
- Reset, then InCSRWen=36'h0_0000_0009 with values idx0=0xA, idx3=0xB, OutReady=1. Expect two beats, OutCSRWen=0x1/0xA then 0x8/0xB; OutFirst on beat 1, OutLast on beat 2; OutCount=2 on both.
- InCSRWen=0 with InValid=1. Expect InReady=1, no OutValid for 3 cycles, state stays IDLE.
- InCSRWen=36'h8_0000_0001 with OutReady low for 4 cycles. Expect OutCSRWen=0x1 and value held stable, InReady=0; after release, beats idx0 then idx35, with OutLast on idx35.
- Back-to-back: set A=0x2, set B=0x4 presented while A's last beat is accepted. Expect B captured that cycle and beats 0x2, 0x4 on consecutive cycles with no gap.
- reset_n pulsed low mid-drain of a 5-bit set. Expect immediate OutValid=0, Busy=0, PendingMask=0; after release, InReady=1.
- TOTAL_CSRS=54 with InCSRWen=bits 36 and 53 set. Expect one-hot 54'h00_0010_0000_0000 then 54'h20_0000_0000_0000; csrindextoaddr yields 0x3B0 then 0x3A2.
